// File: rtl/nrf24_pkg.sv
// Shared types and constants for the nRF24L01 SPI link.
package nrf24_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    HOLD,
    GAP
  } xfer_state_t;

  localparam logic [7:0] R_REGISTER   = 8'h00;
  localparam logic [7:0] W_REGISTER   = 8'h20;
  localparam logic [7:0] R_RX_PAYLOAD = 8'h61;
  localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
  localparam logic [7:0] FLUSH_TX     = 8'hE1;
  localparam logic [7:0] FLUSH_RX     = 8'hE2;
  localparam logic [7:0] NOP          = 8'hFF;

  localparam int unsigned MAX_PAYLOAD = 32;

  // Requested byte counts above the transaction limit are truncated to it.
  function automatic int unsigned clamp_len(input int unsigned req, input int unsigned max_len);
    return (req > max_len) ? max_len : req;
  endfunction

endpackage

// File: rtl/nrf24_spi_xfer_clk_gen.sv
// SCK half-period divider: alternating rise/fall strobes, one cycle before
// the registered SCK edge they cause.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] TICK_AT  = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          tick;

  assign tick      = en && (cnt_q == TICK_AT);
  assign rise_tick = tick && !phase_q;
  assign fall_tick = tick && phase_q;

  // Free-running half-period counter while enabled; phase selects rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (clr) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (en) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      if (tick) phase_q <= ~phase_q;
    end
  end

endmodule

// File: rtl/nrf24_spi_xfer.sv
// Multi-byte SPI mode-0 master for the nRF24L01: command plus payload under
// one CSN assertion, valid/ready byte feed, strobed receive.
module nrf24_spi_xfer
  import nrf24_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5,
  parameter int unsigned MAX_LEN = 33,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_in,
  input  logic             key0_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             spi_sck,
  output logic             spi_mosi,
  output logic             spi_csn,
  input  logic             spi_miso
);

  localparam int unsigned      WAIT_W    = $clog2(CLK_DIV + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CLK_DIV - 1);

  xfer_state_t       state, next_state;
  logic [LEN_W-1:0]  len_q, cnt_q, cnt_inc;
  logic [2:0]        bit_q;
  logic [7:0]        tx_sh, rx_sh;
  logic [WAIT_W-1:0] wait_q;
  logic              rise_tick, fall_tick;
  logic              start_ok, byte_end, wait_end;

  assign start_ok = start && (len != '0);
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign byte_end = (state == SHIFT) && fall_tick && (bit_q == 3'd7);
  assign wait_end = (wait_q == WAIT_LAST);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk_in),
    .rst_n     (key0_rst),
    .en        (state == SHIFT),
    .clr       (state == LOAD),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // State register.
  always_ff @(posedge clk_in or negedge key0_rst) begin
    if (!key0_rst) state <= IDLE;
    else           state <= next_state;
  end

  // Next-state decode; tx_ready is the LOAD-state handshake so the byte
  // following an 8th falling edge can be taken in the same cycle.
  always_comb begin
    next_state = state;
    tx_ready   = 1'b0;
    unique case (state)
      IDLE:  if (start_ok) next_state = LOAD;
      LOAD: begin
        tx_ready = tx_valid;
        if (tx_valid) next_state = SHIFT;
      end
      SHIFT: if (byte_end) next_state = (cnt_inc < len_q) ? LOAD : HOLD;
      HOLD:  if (wait_end) next_state = GAP;
      GAP:   if (wait_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered pin/status outputs.
  always_ff @(posedge clk_in or negedge key0_rst) begin
    if (!key0_rst) begin
      spi_csn  <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      wait_q   <= '0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            len_q   <= LEN_W'(clamp_len(32'(len), MAX_LEN));
            cnt_q   <= '0;
            spi_csn <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          bit_q <= '0;
          if (tx_valid) begin
            tx_sh    <= tx_data;
            spi_mosi <= tx_data[7];
          end
        end
        SHIFT: begin
          if (rise_tick) begin
            spi_sck <= 1'b1;
            rx_sh   <= {rx_sh[6:0], spi_miso};
          end
          if (fall_tick) begin
            spi_sck <= 1'b0;
            if (bit_q == 3'd7) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_sh;
              cnt_q    <= cnt_inc;
            end else begin
              bit_q    <= bit_q + 3'd1;
              tx_sh    <= tx_sh << 1;
              spi_mosi <= tx_sh[6];
            end
          end
        end
        HOLD: begin
          if (wait_end) begin
            wait_q  <= '0;
            spi_csn <= 1'b1;
            done    <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        GAP: begin
          if (wait_end) begin
            wait_q <= '0;
            busy   <= 1'b0;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nrf24_spi_xfer.sv
// Self-checking bench for nrf24_spi_xfer: random transactions against a
// behavioural SPI slave and a cycle-level timing model of the transfer.
module tb_nrf24_spi_xfer;
  import nrf24_pkg::*;

  localparam int unsigned CD = 4;
  localparam int unsigned ML = 33;
  localparam int unsigned LW = $clog2(ML + 1);

  logic          clk_in = 1'b0;
  logic          key0_rst;
  logic          start;
  logic [LW-1:0] len;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          busy;
  logic          done;
  logic          spi_sck;
  logic          spi_mosi;
  logic          spi_csn;
  logic          spi_miso = 1'b0;

  nrf24_spi_xfer #(.CLK_DIV(CD), .MAX_LEN(ML), .LEN_W(LW)) dut (
    .clk_in   (clk_in),
    .key0_rst (key0_rst),
    .start    (start),
    .len      (len),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .done     (done),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_csn  (spi_csn),
    .spi_miso (spi_miso)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Event log filled by the monitor, cycle-stamped.
  int         l_q[$], rise_q[$], fall_q[$], rxv_q[$], done_q[$];
  int         busyf_q[$], csnf_q[$], csnr_q[$];
  logic [7:0] mosi_q[$], rxd_q[$], resp_q[$], force_q[$];

  task automatic clr_q();
    l_q.delete(); rise_q.delete(); fall_q.delete(); rxv_q.delete();
    done_q.delete(); busyf_q.delete(); csnf_q.delete(); csnr_q.delete();
    mosi_q.delete(); rxd_q.delete(); resp_q.delete();
  endtask

  // SPI mode-0 slave: captures MOSI on SCK rise, shifts MISO on SCK fall,
  // presents a new response byte at CSN fall and after every 8th fall.
  logic [7:0] s_resp = '0;
  logic [7:0] s_in = '0;
  int         s_bit = 0;
  int         s_cnt = 0;
  logic       p_sck = 1'b0, p_csn = 1'b1, p_busy = 1'b0;

  task automatic s_next();
    if (force_q.size() > 0) s_resp = force_q.pop_front();
    else s_resp = 8'($urandom);
    resp_q.push_back(s_resp);
    s_bit = 0;
    spi_miso = s_resp[7];
  endtask

  always @(negedge clk_in) begin
    if (tx_ready) l_q.push_back(cyc);
    if (rx_valid) begin rxv_q.push_back(cyc); rxd_q.push_back(rx_data); end
    if (done) done_q.push_back(cyc);
    if (p_busy && !busy) busyf_q.push_back(cyc);
    if (!p_csn && spi_csn) csnr_q.push_back(cyc);
    if (p_csn && !spi_csn) begin csnf_q.push_back(cyc); s_cnt = 0; s_next(); end
    if (!spi_csn && !p_sck && spi_sck) begin
      rise_q.push_back(cyc);
      s_in = {s_in[6:0], spi_mosi};
      s_cnt++;
      if (s_cnt == 8) begin mosi_q.push_back(s_in); s_cnt = 0; end
    end
    if (!spi_csn && p_sck && !spi_sck) begin
      fall_q.push_back(cyc);
      if (s_bit == 7) s_next();
      else begin s_bit++; spi_miso = s_resp[7 - s_bit]; end
    end
    p_sck = spi_sck; p_csn = spi_csn; p_busy = busy;
  end

  int chain_pending = 0;

  // One transaction: request n_req bytes, optional stall before byte stall_idx,
  // optional start pulse mid-transfer, optional immediate follow-on start.
  task automatic do_xfer(input int n_req, input logic [7:0] first, input int stall_idx,
                         input bit mid_start, input bit chain);
    int n_exp, s_cyc, k, guard, g2, stall_bad, bad, rf, last, in_chain;
    bit hs;
    int avail[$];
    int exp_l[$];
    logic [7:0] data[$];
    n_exp = (n_req > int'(ML)) ? int'(ML) : n_req;
    data.push_back(first);
    for (int i = 1; i < n_exp; i++) data.push_back(8'($urandom));
    @(posedge clk_in); #1;
    clr_q();
    in_chain = chain_pending;
    chain_pending = chain;
    s_cyc = cyc;
    start = 1'b1; len = LW'(n_req); tx_data = data[0]; tx_valid = 1'b1;
    avail.push_back(s_cyc);
    k = 0; guard = 0; stall_bad = 0;
    while (k < n_exp && guard < 6000) begin
      @(negedge clk_in); guard++;
      hs = tx_ready;
      @(posedge clk_in); #1;
      start = 1'b0;
      if (hs) begin
        k++;
        if (mid_start && k == 1) begin start = 1'b1; len = LW'($urandom_range(1, 5)); end
        if (k == n_exp) tx_valid = 1'b0;
        else if (k == stall_idx) begin
          tx_valid = 1'b0; tx_data = data[k];
          g2 = 0;
          do begin @(negedge clk_in); g2++; end while (!rx_valid && g2 < 400);
          chk("stall_rx_wait", (g2 < 400), 1);
          repeat (19) begin @(negedge clk_in); if (spi_sck || spi_csn) stall_bad++; end
          @(posedge clk_in); #1;
          tx_valid = 1'b1;
          avail.push_back(cyc);
          chk("stall_pins", stall_bad, 0);
        end else begin
          tx_data = data[k];
          avail.push_back(cyc);
        end
      end
    end
    chk("tx_timeout", (guard < 6000), 1);
    if (start) begin @(posedge clk_in); #1; start = 1'b0; end

    // Reference timing: byte k starts at the later of data availability and
    // the cycle the master is ready for it.
    for (int i = 0; i < n_exp; i++) begin
      rf = (i == 0) ? s_cyc + 1 : exp_l[i-1] + 16 * CD;
      exp_l.push_back((i < avail.size() && avail[i] > rf) ? avail[i] : rf);
    end
    last = exp_l[n_exp-1];

    guard = 0;
    if (chain) begin
      while (cyc != last + 18 * CD - 1 && guard < 6000) begin @(negedge clk_in); guard++; end
    end else begin
      while (busy && guard < 6000) begin @(negedge clk_in); guard++; end
      @(posedge clk_in); #1;
    end
    chk("end_timeout", (guard < 6000), 1);

    chk("nbytes", l_q.size(), n_exp);
    chk("rx_count", rxv_q.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (i < l_q.size()) chk("tx_ready_t", l_q[i], exp_l[i]);
      if (i < mosi_q.size()) chk("mosi_byte", mosi_q[i], data[i]);
      if (i < rxv_q.size()) begin
        chk("rx_valid_t", rxv_q[i], exp_l[i] + 16 * CD);
        chk("rx_data", rxd_q[i], resp_q[i]);
      end
      bad = 0;
      if (fall_q.size() < 8 * (i + 1)) bad = 16;
      else for (int j = 0; j < 8; j++) begin
        if (rise_q[8*i+j] != exp_l[i] + (2*j+1) * CD) bad++;
        if (fall_q[8*i+j] != exp_l[i] + (2*j+2) * CD) bad++;
      end
      chk("sck_edges", bad, 0);
    end
    chk("csn_falls", csnf_q.size(), 1);
    chk("csn_fall_t", (csnf_q.size() > 0) ? csnf_q[0] : -1, s_cyc + 1);
    chk("done_cnt", done_q.size(), 1);
    chk("done_t", (done_q.size() > 0) ? done_q[0] : -1, last + 17 * CD);
    chk("csn_rise_t", (csnr_q.size() > 0) ? csnr_q[0] : -1, last + 17 * CD);
    if (!chain) chk("busy_fall_t", (busyf_q.size() > 0) ? busyf_q[$] : -1, last + 18 * CD);
    if (in_chain) chk("chain_start", (busyf_q.size() > 0) ? busyf_q[0] : -1, s_cyc);
  endtask

  logic [7:0] ops [7];
  int         n, st, g;

  initial begin
    ops[0] = R_REGISTER | 8'h07; ops[1] = W_REGISTER | 8'h01; ops[2] = R_RX_PAYLOAD;
    ops[3] = W_TX_PAYLOAD; ops[4] = FLUSH_TX; ops[5] = FLUSH_RX; ops[6] = NOP;
    key0_rst = 1'b0; start = 1'b0; len = '0; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_csn", spi_csn, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    key0_rst = 1'b1;
    repeat (2) @(posedge clk_in);

    // NOP status read with a fixed slave status byte.
    force_q.push_back(8'h0E);
    do_xfer(1, NOP, -1, 1'b0, 1'b0);
    chk("nop_status", (rxd_q.size() > 0) ? rxd_q[0] : 8'h00, 8'h0E);

    // Two-byte register write, back-to-back bytes.
    do_xfer(2, W_REGISTER, -1, 1'b0, 1'b0);

    // Three bytes with a stall before the second.
    do_xfer(3, ops[$urandom_range(0, 6)], 1, 1'b0, 1'b0);

    // len = 0 is ignored.
    @(posedge clk_in); #1;
    clr_q();
    start = 1'b1; len = '0; tx_valid = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    repeat (30) @(posedge clk_in);
    #1;
    tx_valid = 1'b0;
    chk("len0_csn", csnf_q.size(), 0);
    chk("len0_done", done_q.size(), 0);
    chk("len0_busy", busy, 0);

    // Start pulsed while busy has no effect.
    do_xfer(4, ops[$urandom_range(0, 6)], -1, 1'b1, 1'b0);
    repeat (10) @(posedge clk_in);
    #1;
    chk("mid_start_idle", csnf_q.size(), 1);

    // Oversized request is clamped.
    do_xfer(MAX_PAYLOAD + 8, W_TX_PAYLOAD, -1, 1'b0, 1'b0);

    // Random transactions; the third starts in the very cycle busy drops.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      st = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
      do_xfer(n, ops[$urandom_range(0, 6)], st, 1'b0, (r == 1));
    end

    // Reset during bit 4 of byte 2 aborts cleanly.
    @(posedge clk_in); #1;
    clr_q();
    start = 1'b1; len = LW'(3); tx_data = 8'($urandom); tx_valid = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    g = 0;
    while (rise_q.size() < 12 && g < 2000) begin @(negedge clk_in); g++; end
    chk("abort_wait", (g < 2000), 1);
    @(posedge clk_in); #1;
    key0_rst = 1'b0;
    #1;
    chk("abort_csn", spi_csn, 1);
    chk("abort_sck", spi_sck, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(posedge clk_in);
    #1;
    key0_rst = 1'b1; tx_valid = 1'b0;
    repeat (80) @(posedge clk_in);
    #1;
    chk("abort_rx", rxv_q.size(), 1);
    chk("abort_done", done_q.size(), 0);
    chk("abort_csn_falls", csnf_q.size(), 1);

    do_xfer(2, ops[$urandom_range(0, 6)], -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d, want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
